// File: rtl/l2_stats_pkg.sv
// l2_stats_pkg: counter index map and sizing constants for the L2 class statistics block
package l2_stats_pkg;
  localparam int L2_NUM_CNT = 14;
  localparam int L2_ADDR_W = 4;
  typedef enum logic [L2_ADDR_W-1:0] {
    CNT_TOTAL, CNT_BROADCAST, CNT_MULTICAST, CNT_UNICAST, CNT_USERCAST,
    CNT_OVERSIZE, CNT_RUNT, CNT_IP, CNT_OAM, CNT_ETHERTYPE_LB,
    CNT_SAMEMACS, CNT_PTP_L2, CNT_ARP, CNT_NIC_ENCAPS
  } cnt_idx_e;
endpackage

// File: rtl/l2_stat_cnt.sv
// l2_stat_cnt: one live counter with its shadow copy; L2_STATS_SAT_EN selects saturate instead of wrap
module l2_stat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             inc_i,
  input  logic             snap_i,
  input  logic             snap_clr_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] shadow_o
);
  logic [CNT_W-1:0] live_q, live_d, shadow_q, shadow_d, base;
  always_comb begin
    base = (snap_i && snap_clr_i) ? '0 : live_q;
`ifdef L2_STATS_SAT_EN
    live_d = clr_i ? '0 : (inc_i && !(&base)) ? base + CNT_W'(1) : base;
`else
    live_d = clr_i ? '0 : base + CNT_W'(inc_i);
`endif
    shadow_d = clr_i ? '0 : snap_i ? live_q : shadow_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      live_q   <= '0;
      shadow_q <= '0;
    end else if (en_i) begin
      live_q   <= live_d;
      shadow_q <= shadow_d;
    end
  end
  assign shadow_o = shadow_q;
endmodule

// File: rtl/l2_class_stats.sv
// l2_class_stats: per-class frame counters with atomic snapshot bank and registered read port
// Build option L2_STATS_SAT_EN makes counters saturate instead of wrapping.
module l2_class_stats
  import l2_stats_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int NUM_CNT = L2_NUM_CNT
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clken_i,
  input  logic                 cls_valid_i,
  input  logic [12:0]          cls_flags_i,
  input  logic [NUM_CNT-1:0]   cnt_mask_i,
  input  logic                 snap_i,
  input  logic                 snap_clr_i,
  input  logic                 clr_i,
  input  logic                 rd_en_i,
  input  logic [L2_ADDR_W-1:0] rd_addr_i,
  output logic [CNT_W-1:0]     rd_data_o,
  output logic                 rd_valid_o,
  output logic                 snap_done_o
);
  logic [NUM_CNT-1:0] inc;
  logic [CNT_W-1:0]   shadow [NUM_CNT];
  logic [CNT_W-1:0]   rd_data_q, rd_data_d;
  logic               rd_valid_q, snap_done_q;
  // flag k-1 drives counter k; the total sits at CNT_TOTAL and counts every frame
  assign inc = {NUM_CNT{cls_valid_i}} & cnt_mask_i & {cls_flags_i, 1'b1};
  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    l2_stat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .en_i       (clken_i),
      .inc_i      (inc[i]),
      .snap_i     (snap_i),
      .snap_clr_i (snap_clr_i),
      .clr_i      (clr_i),
      .shadow_o   (shadow[i])
    );
  end
  always_comb begin
    rd_data_d = (rd_addr_i < L2_ADDR_W'(NUM_CNT)) ? shadow[rd_addr_i] : '0;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      snap_done_q <= 1'b0;
    end else if (clken_i) begin
      rd_valid_q  <= rd_en_i;
      snap_done_q <= snap_i && !clr_i;
      if (rd_en_i) rd_data_q <= rd_data_d;
    end
  end
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign snap_done_o = snap_done_q;
endmodule

// File: tb/tb_l2_class_stats.sv
// tb_l2_class_stats: scoreboard bench; reads push expected data, a negedge monitor pops and compares
module tb_l2_class_stats;
  logic        clk = 0, rst_n = 0, clken = 1;
  logic        cls_valid = 0, snap = 0, snap_clr = 0, clr = 0, rd_en = 0;
  logic [12:0] flags = '0;
  logic [13:0] mask = '1;
  logic [3:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_valid, snap_done;
  logic        cls_valid_s = 0, snap_s = 0, rd_en_s = 0;
  logic [3:0]  rd_addr_s = '0;
  logic [3:0]  rd_data_s;
  logic        rd_valid_s, snap_done_s;
  logic [31:0] q [$];
  logic [31:0] q_s [$];
  int n_cmp = 0, n_bad = 0, snap_cnt = 0, snap_cnt_s = 0, sd0;
  always #5 clk = ~clk;
  l2_class_stats dut (
    .clk_i(clk), .rst_n_i(rst_n), .clken_i(clken), .cls_valid_i(cls_valid),
    .cls_flags_i(flags), .cnt_mask_i(mask), .snap_i(snap), .snap_clr_i(snap_clr),
    .clr_i(clr), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .rd_valid_o(rd_valid), .snap_done_o(snap_done)
  );
  l2_class_stats #(.CNT_W(4)) dut_s (
    .clk_i(clk), .rst_n_i(rst_n), .clken_i(1'b1), .cls_valid_i(cls_valid_s),
    .cls_flags_i(13'h0), .cnt_mask_i(14'h3fff), .snap_i(snap_s), .snap_clr_i(1'b0),
    .clr_i(1'b0), .rd_en_i(rd_en_s), .rd_addr_i(rd_addr_s), .rd_data_o(rd_data_s),
    .rd_valid_o(rd_valid_s), .snap_done_o(snap_done_s)
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rd_valid) begin
      if (q.size() == 0) check("unexpected_rd_valid", 32'd1, 32'd0);
      else check("rd_data", rd_data, q.pop_front());
    end
    if (rd_valid_s) begin
      if (q_s.size() == 0) check("unexpected_rd_valid_s", 32'd1, 32'd0);
      else check("rd_data_s", {28'd0, rd_data_s}, q_s.pop_front());
    end
    if (snap_done) snap_cnt++;
    if (snap_done_s) snap_cnt_s++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    rd_en = 1; rd_addr = a; q.push_back(e);
    tick();
    rd_en = 0;
  endtask
  task automatic do_snap(input logic c);
    snap = 1; snap_clr = c;
    tick();
    snap = 0; snap_clr = 0;
  endtask
  task automatic frame(input logic [12:0] f, input int n);
    repeat (n) begin
      cls_valid = 1; flags = f;
      tick();
    end
    cls_valid = 0; flags = '0;
  endtask
  task automatic frame_s(input int n);
    repeat (n) begin
      cls_valid_s = 1;
      tick();
    end
    cls_valid_s = 0;
  endtask
  task automatic snap_rd_s(input logic [31:0] e);
    snap_s = 1; tick(); snap_s = 0;
    rd_en_s = 1; rd_addr_s = 0; q_s.push_back(e); tick(); rd_en_s = 0;
  endtask
  initial begin
    #12;
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", {31'd0, rd_valid}, 0);
    check("rst_snap_done", {31'd0, snap_done}, 0);
    @(posedge clk); #1 rst_n = 1;
    tick();
    // broadcast|ip frames
    frame(13'h0041, 5);
    sd0 = snap_cnt;
    do_snap(0);
    tick();
    check("snap_done_once", snap_cnt - sd0, 1);
    for (int a = 0; a < 16; a++) rd(4'(a), (a == 0 || a == 1 || a == 7) ? 32'd5 : 32'd0);
    // frame coincident with clearing snap at total 9
    frame(13'h0, 4);
    cls_valid = 1; snap = 1; snap_clr = 1;
    tick();
    cls_valid = 0; snap = 0; snap_clr = 0;
    rd(0, 9); rd(1, 5); rd(7, 5);
    do_snap(0);
    rd(0, 1); rd(1, 0); rd(7, 0);
    // masked multicast
    do_snap(1);
    mask[2] = 0;
    frame(13'h0002, 3);
    do_snap(1);
    mask = '1;
    rd(0, 3); rd(2, 0);
    // back-to-back reads, in-range then out-of-range
    frame(13'h0004, 2);
    do_snap(1);
    rd_en = 1; rd_addr = 3; q.push_back(2);
    tick();
    rd_addr = 15; q.push_back(0);
    tick();
    rd_en = 0;
    rd(3, 2);
    tick(); tick();
    check("rd_data_hold", rd_data, 2);
    // read coincident with snap sees old shadow
    frame(13'h0004, 1);
    snap = 1; rd_en = 1; rd_addr = 3; q.push_back(2);
    tick();
    snap = 0; rd_en = 0;
    rd(3, 1); rd(0, 1);
    tick();
    // strobes with clken low are ignored
    sd0 = snap_cnt;
    clken = 0; cls_valid = 1; snap = 1; clr = 1; rd_en = 1; rd_addr = 0;
    tick(); tick();
    cls_valid = 0; snap = 0; clr = 0; rd_en = 0; clken = 1;
    tick();
    check("clken_no_snap_done", snap_cnt - sd0, 0);
    do_snap(0);
    rd(0, 1); rd(3, 1);
    // overflow on 4-bit counters
    frame_s(15);
    snap_rd_s(15);
    frame_s(1);
`ifdef L2_STATS_SAT_EN
    snap_rd_s(15);
    frame_s(1);
    snap_rd_s(15);
`else
    snap_rd_s(0);
    frame_s(1);
    snap_rd_s(1);
`endif
    tick();
    check("snap_done_s_cnt", snap_cnt_s, 3);
    // clear beats coincident frame and snap
    frame(13'h0041, 3);
    sd0 = snap_cnt;
    clr = 1; cls_valid = 1; flags = 13'h0041; snap = 1;
    tick();
    clr = 0; cls_valid = 0; flags = '0; snap = 0;
    tick();
    check("clr_no_snap_done", snap_cnt - sd0, 0);
    rd(0, 0); rd(1, 0);
    do_snap(0);
    rd(0, 0); rd(7, 0);
    // reset mid-stream with a pending read
    frame(13'h0041, 3);
    do_snap(0);
    rd(0, 3);
    frame(13'h0041, 2);
    rd_en = 1; rd_addr = 0;
    #2 rst_n = 0;
    #1 rd_en = 0;
    check("midrst_rd_data", rd_data, 0);
    check("midrst_rd_valid", {31'd0, rd_valid}, 0);
    check("midrst_snap_done", {31'd0, snap_done}, 0);
    tick();
    rst_n = 1;
    tick();
    do_snap(0);
    rd(0, 0); rd(1, 0); rd(7, 0);
    tick(); tick(); tick();
    check("queue_drained", q.size(), 0);
    check("queue_s_drained", q_s.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
